cam_capture_crop: RTL
=====================

Name: cam_capture_crop

Overview:
- Synchronous camera capture front end, clocked by the camera pixel clock.
- Assembles OV7670 byte pairs into RGB565 pixels and tracks the x/y position of each pixel within the frame.
- Crops a WIN_W x WIN_H window and emits registered write requests (address, RGB565 data, 8-bit gray) to the frame buffer port A writer.
- Also produces the frame-done, line-count and error indications used by the top level and the seven-segment debug display.

Parameters:
- IMG_W, 640: active pixels per line.
- IMG_H, 480: active lines per frame.
- WIN_X0, 0: first captured column.
- WIN_Y0, 0: first captured row.
- WIN_W, 150: crop window width.
- WIN_H, 150: crop window height.
- ADDR_W, 15: buffer address width; WIN_W*WIN_H must be <= 2^ADDR_W.

Ports:
- clk  in  1  camera pixel clock (PCLK); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cam_vsync  in  1  frame sync, high = vertical blanking.
- cam_href  in  1  line valid, high = bytes valid.
- cam_data  in  8  camera byte bus D7..D0.
- capture_en  in  1  frame capture enable (button); sampled only at frame start.
- wr_en  out  1  buffer write strobe, one cycle per windowed pixel.
- wr_addr  out  ADDR_W  buffer address.
- wr_data  out  16  RGB565 pixel, first byte in [15:8].
- wr_gray  out  8  luminance of wr_data.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- line_cnt  out  9  current y counter (debug display).
- frame_cnt  out  8  count of captured frames, wraps 255->0.
- err_geom  out  1  sticky geometry error flag.

Behaviour:
- Reset (async, rst_n=0): state=SYNC; all outputs 0; x, y, byte phase and hi-byte register cleared. Any partial frame is discarded.
- States:
  - SYNC: wait for cam_vsync=1, then go to VBLANK. No frame is captured until a full blanking interval has been seen after reset.
  - VBLANK: on cam_vsync=0, go to FRAME if capture_en=1, else go to SKIP. x, y and phase are cleared on entry to FRAME.
  - FRAME: capture. On cam_vsync=1, go to VBLANK and assert frame_done for exactly one cycle; frame_cnt increments in the same cycle.
  - SKIP: ignore all data, no frame_done; on cam_vsync=1, go to VBLANK. A capture_en change mid-frame has no effect until the next frame start.
- Byte assembly (FRAME only, cam_href=1):
  - phase 0: latch cam_data into hi, set phase to 1.
  - phase 1: form pixel {hi, cam_data} at the current (x,y), then x+1 and phase to 0.
- Line end: on the cycle where cam_href=0 after cam_href=1:
  - x <= 0 and phase <= 0.
  - y <= y+1 if x != 0.
  - If phase was 1, the orphan byte is dropped and err_geom is set.
- Geometry limits:
  - A pixel with x >= IMG_W or y >= IMG_H is not written and sets err_geom.
  - x and y saturate and do not wrap.
  - err_geom is cleared only by reset.
- Window write: a pixel completed in cycle N produces a registered output in cycle N+1:
  - wr_en=1 iff WIN_X0 <= x < WIN_X0+WIN_W and WIN_Y0 <= y < WIN_Y0+WIN_H; otherwise wr_en=0.
  - wr_addr = (y-WIN_Y0)*WIN_W + (x-WIN_X0), computed without overflow at ADDR_W.
  - wr_data = {hi, lo}.
  - wr_addr, wr_data and wr_gray hold their values when wr_en=0.
- Gray arithmetic:
  - R5=wr_data[15:11], G6=[10:5], B5=[4:0].
  - Expand to 8 bits: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - wr_gray = (77*R8 + 150*G8 + 29*B8) >> 8, using a 16-bit sum; the maximum is 65280, so no overflow.
- Simultaneous events:
  - cam_vsync rising while cam_href=1: the vsync transition wins; any pending hi byte is dropped without setting err_geom; frame_done still pulses.
  - A pixel completing in the last cycle before vsync rises is still written, one cycle later.
- line_cnt = y at all times; it holds its last value during VBLANK and SKIP.

Test Plan:
- Reset, vsync 1->0 with capture_en=1, one line of bytes F8,00,07,E0:
  - cycle after byte 2: wr_en=1, addr=0, data=F800, gray=76.
  - cycle after byte 4: wr_en=1, addr=1, data=07E0, gray=149.
- Full 640x480 frame of 0xFFFF:
  - exactly 22500 wr_en pulses.
  - last write addr=22499, gray=255.
  - no write for x=150 or y=150.
  - frame_done a single cycle after vsync rise; frame_cnt=1.
- capture_en=0 at vsync fall, raised mid-frame:
  - zero writes and no frame_done for that frame.
  - next frame fully captured; frame_cnt increments by 1 only.
- Line ending after 3 bytes (F8,00,1F):
  - one write (addr 0); err_geom=1 and stays high.
  - next line's first pixel goes to addr 150.
- rst_n pulsed low mid-line:
  - all outputs 0 immediately (async).
  - subsequent href bytes before any vsync high produce no writes.
  - capture resumes only after a vsync 1->0 transition.
- Line of 642 pixels: pixels 640 and 641 are not written and err_geom=1; line_cnt advances by exactly 1.

Source files
------------

// File: rtl/cam_capture_crop.sv
// rtl/cam_capture_crop.sv - OV7670 RGB565 capture, window crop and frame-buffer write port
module cam_capture_crop #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 0,
  parameter int WIN_W  = 150,
  parameter int WIN_H  = 150,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [7:0]        wr_gray,
  output logic              frame_done,
  output logic [8:0]        line_cnt,
  output logic [7:0]        frame_cnt,
  output logic              err_geom
);

  // x is wider than any legal line so an over-long line is detected before saturation
  localparam int X_W = 11;
  localparam logic [31:0] C_IMG_W  = IMG_W;
  localparam logic [31:0] C_IMG_H  = IMG_H;
  localparam logic [31:0] C_WIN_X0 = WIN_X0;
  localparam logic [31:0] C_WIN_Y0 = WIN_Y0;
  localparam logic [31:0] C_WIN_W  = WIN_W;
  localparam logic [31:0] C_WIN_H  = WIN_H;

  typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_FRAME, S_SKIP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [X_W-1:0]    r_x;
  logic [8:0]        r_y;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic              r_href_d;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic [7:0]        r_wr_gray;
  logic              r_frame_done;
  logic [7:0]        r_frame_cnt;
  logic              r_err;

  logic        w_start;
  logic        w_active;
  logic        w_done;
  logic [31:0] w_x;
  logic [31:0] w_y;
  logic [31:0] w_dx;
  logic [31:0] w_dy;
  logic [31:0] w_addr_full;
  logic        w_in_img;
  logic        w_in_win;
  logic [15:0] w_pixel;
  logic [7:0]  w_r8;
  logic [7:0]  w_g8;
  logic [7:0]  w_b8;
  logic [15:0] w_gray_sum;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_SYNC;
    else        r_state <= w_state_nxt;
  end

  // next-state: a frame only starts after a complete blanking interval
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC:   if (cam_vsync)  w_state_nxt = S_VBLANK;
      S_VBLANK: if (!cam_vsync) w_state_nxt = capture_en ? S_FRAME : S_SKIP;
      S_FRAME:  if (cam_vsync)  w_state_nxt = S_VBLANK;
      S_SKIP:   if (cam_vsync)  w_state_nxt = S_VBLANK;
      default:                  w_state_nxt = S_SYNC;
    endcase
  end

  // state decode: vsync rising inside a frame overrides any byte on the bus
  always_comb begin
    w_start  = (r_state == S_VBLANK) && !cam_vsync && capture_en;
    w_active = (r_state == S_FRAME) && !cam_vsync;
    w_done   = (r_state == S_FRAME) && cam_vsync;
  end

  // window test, buffer address and luminance of the pixel completing this cycle
  always_comb begin
    w_x         = {{(32-X_W){1'b0}}, r_x};
    w_y         = {23'd0, r_y};
    w_dx        = w_x - C_WIN_X0;
    w_dy        = w_y - C_WIN_Y0;
    w_in_img    = (w_x < C_IMG_W) && (w_y < C_IMG_H);
    // unsigned wrap makes positions left of / above the window fail the bound test
    w_in_win    = (w_dx < C_WIN_W) && (w_dy < C_WIN_H);
    w_addr_full = w_dy * C_WIN_W + w_dx;
    w_pixel     = {r_hi, cam_data};
    w_r8        = {w_pixel[15:11], w_pixel[15:13]};
    w_g8        = {w_pixel[10:5],  w_pixel[10:9]};
    w_b8        = {w_pixel[4:0],   w_pixel[4:2]};
    w_gray_sum  = 16'd77  * {8'd0, w_r8}
                + 16'd150 * {8'd0, w_g8}
                + 16'd29  * {8'd0, w_b8};
  end

  // byte assembly, x/y tracking, geometry errors and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_href_d     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_gray    <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= w_done;
      r_href_d     <= cam_href;
      if (w_done) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_phase     <= 1'b0;
      end
      if (w_start) begin
        r_x      <= '0;
        r_y      <= '0;
        r_phase  <= 1'b0;
        r_href_d <= 1'b0;
      end else if (w_active && cam_href) begin
        if (!r_phase) begin
          r_hi    <= cam_data;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          r_x     <= (&r_x) ? r_x : r_x + 1'b1;
          if (!w_in_img) begin
            r_err <= 1'b1;
          end else if (w_in_win) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= ADDR_W'(w_addr_full);
            r_wr_data <= w_pixel;
            r_wr_gray <= 8'(w_gray_sum >> 8);
          end
        end
      end else if (w_active && r_href_d) begin
        r_x     <= '0;
        r_phase <= 1'b0;
        if (r_x != '0) r_y <= (&r_y) ? r_y : r_y + 1'b1;
        if (r_phase)   r_err <= 1'b1;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign wr_gray    = r_wr_gray;
  assign frame_done = r_frame_done;
  assign line_cnt   = r_y;
  assign frame_cnt  = r_frame_cnt;
  assign err_geom   = r_err;

endmodule
